// File: rtl/sdram_port_arbiter_if.sv
// Bus bundle between the two Avalon-MM requesters, the port arbiter and the SDRAM controller slave.
// slave = arbiter view, master = environment (requesters + controller) view.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  localparam int BE_W = DATA_W / 8;

  // requester side
  logic [2*ADDR_W-1:0] req_address;
  logic [1:0]          req_read;
  logic [1:0]          req_write;
  logic [2*DATA_W-1:0] req_writedata;
  logic [2*BE_W-1:0]   req_byteenable;
  logic [1:0]          req_waitrequest;
  logic [DATA_W-1:0]   req_readdata;
  logic [1:0]          req_readdatavalid;

  // controller side
  logic [ADDR_W-1:0]   sdram_address;
  logic                sdram_read;
  logic                sdram_write;
  logic [DATA_W-1:0]   sdram_writedata;
  logic [BE_W-1:0]     sdram_byteenable;
  logic                sdram_waitrequest;
  logic [DATA_W-1:0]   sdram_readdata;
  logic                sdram_readdatavalid;

  modport slave (
    input  req_address, req_read, req_write, req_writedata, req_byteenable,
    input  sdram_waitrequest, sdram_readdata, sdram_readdatavalid,
    output req_waitrequest, req_readdata, req_readdatavalid,
    output sdram_address, sdram_read, sdram_write, sdram_writedata, sdram_byteenable
  );

  modport master (
    output req_address, req_read, req_write, req_writedata, req_byteenable,
    output sdram_waitrequest, sdram_readdata, sdram_readdatavalid,
    input  req_waitrequest, req_readdata, req_readdatavalid,
    input  sdram_address, sdram_read, sdram_write, sdram_writedata, sdram_byteenable
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-requester Avalon-MM arbiter for the SDRAM controller slave, with a read-ID FIFO steering returns.
// Define ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module sdram_port_arbiter #(
  parameter int ADDR_W   = 24,
  parameter int DATA_W   = 16,
  parameter int MAX_PEND = 8
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  sdram_port_arbiter_if.slave   bus,
  output logic                  grant_id
);
  localparam int BE_W = DATA_W / 8;
  localparam int PW   = $clog2(MAX_PEND);
  localparam int CW   = PW + 1;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t          state_q, state_d;
  logic            grant_q, grant_d;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            id_mem_q [MAX_PEND];

  logic [1:0]      active;
  logic            winner;
  logic            fifo_empty, fifo_full;
  logic            fifo_push, fifo_pop;
  logic            head_id;
  logic            g_rd, g_wr;
  logic            rd_block;
  logic            accept;
  logic            sd_read, sd_write;
  logic [1:0]      wait_o;

  assign active     = bus.req_read | bus.req_write;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(MAX_PEND));
  assign fifo_pop   = bus.sdram_readdatavalid & ~fifo_empty;
  assign head_id    = id_mem_q[rd_ptr_q];

  // When only one requester is active, ~active[0] picks the active one.
  always_comb begin
`ifdef ARB_FIXED_PRIO_EN
    winner = ~active[0];
`else
    if (&active) winner = ~grant_q;
    else         winner = ~active[0];
`endif
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    g_rd     = 1'b0;
    g_wr     = 1'b0;
    rd_block = 1'b0;
    accept   = 1'b0;
    sd_read  = 1'b0;
    sd_write = 1'b0;
    wait_o   = 2'b11;
    case (state_q)
      IDLE: begin
        if (|active) begin
          grant_d = winner;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Write wins if a requester illegally raises both strobes.
        g_wr     = bus.req_write[grant_q];
        g_rd     = bus.req_read[grant_q] & ~g_wr;
        rd_block = fifo_full & g_rd & ~fifo_pop;
        sd_read  = g_rd & ~rd_block;
        sd_write = g_wr;
        wait_o[grant_q] = bus.sdram_waitrequest | rd_block;
        accept   = (sd_read | sd_write) & ~bus.sdram_waitrequest;
        if (accept || !active[grant_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_push = accept & sd_read;
  assign count_d   = count_q + CW'(fifo_push) - CW'(fifo_pop);

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q  <= IDLE;
      grant_q  <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      count_q  <= count_d;
      if (fifo_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk_clk) begin
    if (fifo_push) id_mem_q[wr_ptr_q] <= grant_q;
  end

  assign bus.sdram_address     = bus.req_address[int'(grant_q)*ADDR_W +: ADDR_W];
  assign bus.sdram_writedata   = bus.req_writedata[int'(grant_q)*DATA_W +: DATA_W];
  assign bus.sdram_byteenable  = bus.req_byteenable[int'(grant_q)*BE_W +: BE_W];
  assign bus.sdram_read        = sd_read;
  assign bus.sdram_write       = sd_write;
  assign bus.req_waitrequest   = wait_o;
  assign bus.req_readdata      = bus.sdram_readdata;
  assign bus.req_readdatavalid = fifo_pop ? (head_id ? 2'b10 : 2'b01) : 2'b00;
  assign grant_id              = grant_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: per-cycle queue-based reference model plus literal checks.
module tb_sdram_port_arbiter;
  localparam int ADDR_W   = 24;
  localparam int DATA_W   = 16;
  localparam int MAX_PEND = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic grant_id;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   model_on = 1'b0;

  // reference model state
  bit   m_busy  = 1'b0;
  bit   m_owner = 1'b0;
  bit   m_last  = 1'b1;
  bit   pend[$];

  always #5 clk = ~clk;

  sdram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_PEND(MAX_PEND)) dut (
    .clk_clk    (clk),
    .reset_reset(rst),
    .bus        (bus.slave),
    .grant_id   (grant_id)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model evaluates on the falling edge; inputs are stable from posedge+1 to the next posedge.
  always @(negedge clk) begin
    logic [1:0] act, exp_wait, exp_rdv;
    logic       exp_rd, exp_wr, isw, isr, blocked, pop, acc;
    act      = bus.req_read | bus.req_write;
    pop      = bus.sdram_readdatavalid && (pend.size() > 0);
    exp_rdv  = 2'b00;
    if (pop) exp_rdv = pend[0] ? 2'b10 : 2'b01;
    exp_rd   = 1'b0;
    exp_wr   = 1'b0;
    isw      = 1'b0;
    isr      = 1'b0;
    blocked  = 1'b0;
    acc      = 1'b0;
    exp_wait = 2'b11;
    if (m_busy) begin
      isw     = bus.req_write[m_owner];
      isr     = bus.req_read[m_owner] && !isw;
      blocked = isr && (pend.size() >= MAX_PEND) && !pop;
      exp_wr  = isw;
      exp_rd  = isr && !blocked;
      exp_wait[m_owner] = bus.sdram_waitrequest || blocked;
      acc     = (exp_rd || exp_wr) && !bus.sdram_waitrequest;
    end
    if (model_on) begin
      chk("m_read",  bus.sdram_read, exp_rd);
      chk("m_write", bus.sdram_write, exp_wr);
      chk("m_wait",  bus.req_waitrequest, exp_wait);
      chk("m_rdv",   bus.req_readdatavalid, exp_rdv);
      chk("m_grant", grant_id, m_last);
      if (m_busy) begin
        chk("m_addr", bus.sdram_address, bus.req_address[m_owner*ADDR_W +: ADDR_W]);
        chk("m_wdata", bus.sdram_writedata, bus.req_writedata[m_owner*DATA_W +: DATA_W]);
        chk("m_be", bus.sdram_byteenable, bus.req_byteenable[m_owner*2 +: 2]);
      end
      if (pop) chk("m_rdata", bus.req_readdata, bus.sdram_readdata);
    end
    if (rst) begin
      m_busy   = 1'b0;
      m_last   = 1'b1;
      pend.delete();
      model_on = 1'b1;
    end else if (model_on) begin
      if (pop) void'(pend.pop_front());
      if (acc && exp_rd) pend.push_back(m_owner);
      if (m_busy) begin
        if (acc || !act[m_owner]) m_busy = 1'b0;
      end else if (act != 2'b00) begin
`ifdef ARB_FIXED_PRIO_EN
        m_owner = act[0] ? 1'b0 : 1'b1;
`else
        if (act == 2'b11) m_owner = !m_last;
        else              m_owner = act[0] ? 1'b0 : 1'b1;
`endif
        m_last = m_owner;
        m_busy = 1'b1;
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.req_read            = 2'b00;
    bus.req_write           = 2'b00;
    bus.sdram_waitrequest   = 1'b0;
    bus.sdram_readdatavalid = 1'b0;
    bus.sdram_readdata      = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_reqs();
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  logic exp_g [4];

  initial begin
`ifdef ARB_FIXED_PRIO_EN
    exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    bus.req_address    = {24'h000006, 24'h000005};
    bus.req_writedata  = {16'h0000, 16'h0000};
    bus.req_byteenable = 4'b0000;
    clear_reqs();

    // reset values
    do_reset();
    #2;
    chk("rst_read", bus.sdram_read, 1'b0);
    chk("rst_write", bus.sdram_write, 1'b0);
    chk("rst_wait", bus.req_waitrequest, 2'b11);
    chk("rst_rdv", bus.req_readdatavalid, 2'b00);
    chk("rst_grant", grant_id, 1'b1);
    nxt();

    // single write from requester 0
    bus.req_address    = {24'h000006, 24'h000010};
    bus.req_writedata  = {16'h0000, 16'hBEEF};
    bus.req_byteenable = 4'b0011;
    bus.req_write      = 2'b01;
    #2;
    chk("wr_c1_write", bus.sdram_write, 1'b0);
    chk("wr_c1_wait", bus.req_waitrequest, 2'b11);
    nxt();
    #2;
    chk("wr_c2_write", bus.sdram_write, 1'b1);
    chk("wr_c2_addr", bus.sdram_address, 24'h000010);
    chk("wr_c2_data", bus.sdram_writedata, 16'hBEEF);
    chk("wr_c2_be", bus.sdram_byteenable, 2'b11);
    chk("wr_c2_wait0", bus.req_waitrequest[0], 1'b0);
    chk("wr_c2_grant", grant_id, 1'b0);
    nxt();
    bus.req_write = 2'b00;
    #2;
    chk("wr_c3_write", bus.sdram_write, 1'b0);
    nxt();

    // return strobe with nothing outstanding
    bus.sdram_readdatavalid = 1'b1;
    bus.sdram_readdata      = 16'hDEAD;
    #2;
    chk("empty_rdv", bus.req_readdatavalid, 2'b00);
    nxt();
    bus.sdram_readdatavalid = 1'b0;

    // both requesters hold reads continuously
    do_reset();
    bus.req_address = {24'h000006, 24'h000005};
    bus.req_read    = 2'b11;
    for (int i = 0; i < 8; i++) begin
      #2;
      chk("both_read", bus.sdram_read, (i % 2 == 1) ? 1'b1 : 1'b0);
      if (i % 2 == 1) begin
        chk("both_grant", grant_id, exp_g[i/2]);
        chk("both_addr", bus.sdram_address, exp_g[i/2] ? 24'h000006 : 24'h000005);
      end
      nxt();
    end
    bus.req_read = 2'b00;
    nxt();

    // requester 1 fills the read-ID FIFO
    do_reset();
    bus.req_read = 2'b10;
    for (int i = 0; i < 16; i++) begin
      #2;
      if (i % 2 == 1) chk("fill_acc", {bus.req_waitrequest[1], bus.sdram_read}, 2'b01);
      nxt();
    end
    nxt();
    #2;
    chk("full_wait", bus.req_waitrequest[1], 1'b1);
    chk("full_read", bus.sdram_read, 1'b0);
    nxt();
    #2;
    chk("full_wait2", bus.req_waitrequest[1], 1'b1);
    bus.sdram_readdatavalid = 1'b1;
    bus.sdram_readdata      = 16'h0A0A;
    #1;
    chk("pop_read", bus.sdram_read, 1'b1);
    chk("pop_wait", bus.req_waitrequest[1], 1'b0);
    chk("pop_rdv", bus.req_readdatavalid, 2'b10);
    chk("pop_rdata", bus.req_readdata, 16'h0A0A);
    nxt();
    bus.sdram_readdatavalid = 1'b0;
    nxt();
    #2;
    chk("still_full", bus.req_waitrequest[1], 1'b1);
    bus.req_read = 2'b00;
    nxt();
    nxt();

    // interleaved reads, 3-cycle return latency
    do_reset();
    bus.req_address = {24'h000006, 24'h000005};
    bus.req_read    = 2'b11;
    nxt();
    #2;
    chk("il_r0_read", bus.sdram_read, 1'b1);
    chk("il_r0_addr", bus.sdram_address, 24'h000005);
    chk("il_r0_grant", grant_id, 1'b0);
    nxt();
    bus.req_read = 2'b10;
    nxt();
    #2;
    chk("il_r1_read", bus.sdram_read, 1'b1);
    chk("il_r1_addr", bus.sdram_address, 24'h000006);
    chk("il_r1_grant", grant_id, 1'b1);
    nxt();
    bus.req_read            = 2'b00;
    bus.sdram_readdatavalid = 1'b1;
    bus.sdram_readdata      = 16'h1111;
    #2;
    chk("il_ret0_rdv", bus.req_readdatavalid, 2'b01);
    chk("il_ret0_data", bus.req_readdata, 16'h1111);
    nxt();
    bus.sdram_readdatavalid = 1'b0;
    nxt();
    bus.sdram_readdatavalid = 1'b1;
    bus.sdram_readdata      = 16'h2222;
    #2;
    chk("il_ret1_rdv", bus.req_readdatavalid, 2'b10);
    chk("il_ret1_data", bus.req_readdata, 16'h2222);
    nxt();
    bus.sdram_readdatavalid = 1'b0;
    nxt();

    // reset with three reads outstanding
    do_reset();
    bus.req_read = 2'b01;
    for (int i = 0; i < 7; i++) nxt();
    bus.sdram_waitrequest = 1'b1;
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    bus.req_read          = 2'b00;
    bus.sdram_waitrequest = 1'b0;
    #2;
    chk("mid_rst_read", bus.sdram_read, 1'b0);
    chk("mid_rst_wait", bus.req_waitrequest, 2'b11);
    chk("mid_rst_rdv", bus.req_readdatavalid, 2'b00);
    chk("mid_rst_grant", grant_id, 1'b1);
    nxt();
    bus.sdram_readdatavalid = 1'b1;
    bus.sdram_readdata      = 16'h3333;
    #2;
    chk("post_rst_drop", bus.req_readdatavalid, 2'b00);
    nxt();
    bus.sdram_readdatavalid = 1'b0;
    bus.req_read            = 2'b10;
    nxt();
    #2;
    chk("post_rst_grant", grant_id, 1'b1);
    chk("post_rst_read", bus.sdram_read, 1'b1);
    nxt();
    bus.req_read            = 2'b00;
    bus.sdram_readdatavalid = 1'b1;
    bus.sdram_readdata      = 16'h4444;
    #2;
    chk("post_rst_ret", bus.req_readdatavalid, 2'b10);
    chk("post_rst_data", bus.req_readdata, 16'h4444);
    nxt();
    clear_reqs();
    nxt();
    nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single Avalon-MM slave port of the SDRAM controller (16-bit bus, 32 MB part) between two Avalon-MM requesters, e.g. CPU data master and a DMA/LED-pattern master.
- Grants one requester per transaction using round-robin arbitration.
- Tracks outstanding pipelined reads in an ID FIFO so that returning read data is steered to the requester that issued it.

Parameters:
- ADDR_W, 24, word address width toward SDRAM controller (16M x 16-bit words).
- DATA_W, 16, data width; byteenable width is DATA_W/8.
- MAX_PEND, 8, maximum outstanding reads; power of 2, minimum 2.

Ports:
- clk_clk  input  1  system clock; all logic on rising edge.
- reset_reset  input  1  synchronous active-high reset.
- req_address  input  2*ADDR_W  requester i address at [i*ADDR_W +: ADDR_W].
- req_read  input  2  per-requester read strobe.
- req_write  input  2  per-requester write strobe.
- req_writedata  input  2*DATA_W  packed write data.
- req_byteenable  input  2*DATA_W/8  packed byte enables.
- req_waitrequest  output  2  per-requester stall.
- req_readdata  output  DATA_W  shared read data bus, qualified per requester by req_readdatavalid.
- req_readdatavalid  output  2  one-hot read return strobe.
- sdram_address  output  ADDR_W  to SDRAM controller.
- sdram_read  output  1  read command.
- sdram_write  output  1  write command.
- sdram_writedata  output  DATA_W  write data.
- sdram_byteenable  output  DATA_W/8  byte enables; drive DQM via the controller.
- sdram_waitrequest  input  1  controller stall.
- sdram_readdata  input  DATA_W  controller read data.
- sdram_readdatavalid  input  1  controller read return strobe.
- grant_id  output  1  currently/last granted requester (debug).

Behaviour:
- Reset values:
  - state = IDLE.
  - sdram_read = sdram_write = 0.
  - req_waitrequest = 2'b11.
  - req_readdatavalid = 0.
  - grant_id = 1, so requester 0 wins the first tie.
  - ID FIFO empty, count = 0.
- Request definition: requester i is active when req_read[i] | req_write[i]. Asserting both read and write is illegal; write takes precedence.
- IDLE state:
  - If any request is active, register the winner into grant_id and go to GRANT.
  - Round-robin rule: when both are active, the requester not equal to the previous grant_id wins.
  - If no request is active, stay in IDLE. All req_waitrequest are high.
- GRANT state:
  - sdram_address, writedata and byteenable are driven combinationally from the granted slice.
  - sdram_read = req_read[g] & ~rd_block.
  - sdram_write = req_write[g].
  - rd_block = (count == MAX_PEND) & req_read[g] & ~fifo_pop_this_cycle.
  - req_waitrequest[g] = sdram_waitrequest | rd_block. The non-granted requester sees waitrequest = 1.
  - Accept occurs when (sdram_read | sdram_write) & ~sdram_waitrequest. On accept, go to IDLE; grant_id is held.
  - Throughput: minimum 2 cycles per transaction; arbitration latency is 1 cycle from request to grant.
  - If the granted requester drops both strobes before accept (protocol violation), return to IDLE with nothing issued.
- Read ID FIFO:
  - On an accepted read, push g.
  - On sdram_readdatavalid, pop the head h. In the same cycle, req_readdatavalid[h] = 1 and req_readdata = sdram_readdata (combinational, 0 added latency).
  - Simultaneous push and pop: count is unchanged, and both entries are handled correctly.
  - Wrap-around: pointers are log2(MAX_PEND) bits and wrap naturally; count is log2(MAX_PEND)+1 bits.
  - FIFO full: reads stall via rd_block; writes are never blocked by FIFO state.
  - sdram_readdatavalid with an empty FIFO: data is dropped, req_readdatavalid stays 0, and count does not underflow.
- Ordering: the controller returns reads in order, so per-requester order is preserved.
- Reset mid-operation: FIFO is cleared and state goes to IDLE. Read returns arriving after reset are dropped (empty-FIFO rule).

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- When defined, arbitration in IDLE is fixed priority: requester 0 always wins ties and grant_id history is ignored.
- When undefined, round-robin as specified above.
- All other behaviour is identical in both cases.

Test Plan:
- Reset, then requester 0 writes addr 0x000010, data 0xBEEF, byteenable 2'b11, with sdram_waitrequest = 0:
  - sdram_write pulses in cycle 2 after the request with the same address and data.
  - req_waitrequest[0] is low in that cycle.
- Both requesters hold reads continuously:
  - grant_id alternates 0,1,0,1 and sdram_read is issued every 2nd cycle.
  - With ARB_FIXED_PRIO_EN defined, grant_id is always 0.
- Requester 1 issues 8 reads while the controller returns none:
  - 9th read stalls with req_waitrequest[1] = 1.
  - On the first sdram_readdatavalid the 9th read is accepted in the same cycle, and count stays 8.
- Interleaved reads r0 (addr 0x5) and r1 (addr 0x6):
  - Controller returns 0x1111 then 0x2222 with 3-cycle latency.
  - req_readdatavalid = 2'b01 with 0x1111, then 2'b10 with 0x2222.
- sdram_readdatavalid pulse while the FIFO is empty:
  - req_readdatavalid stays 2'b00 and count stays 0.
- Assert reset_reset with 3 reads outstanding:
  - Outputs return to reset values next cycle.
  - Later sdram_readdatavalid pulses are dropped.
